alarm_input_conditioner: RTL and testbench

Front-end stage feeding the security alarm FSM's arm, sensor and on inputs. It synchronizes the three raw pad inputs, debounces them, and converts the arm button into a single long-press arm pulse. It latches a sensor trip until it is explicitly cleared and counts rejected sensor glitches. Every output is registered and drives the alarm FSM directly.

---
 rtl/alarm_input_conditioner.sv | 160 ++++++++++++++++
 tb/tb_alarm_input_conditioner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_input_conditioner.sv
// Alarm pad front end: 2-flop sync + debounce on arm/sensor/on, long-press arm pulse,
// sticky sensor trip with clear, and a saturating sensor glitch counter.
module alarm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_arm,
    input  logic       raw_sensor,
    input  logic       raw_on,
    input  logic       clear,
    output logic       arm_out,
    output logic       sensor_out,
    output logic       on_out,
    output logic       sensor_edge,
    output logic       arm_db,
    output logic       sensor_db,
    output logic [3:0] glitch_cnt
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        FIRE     = 2'd2,
        WAIT_REL = 2'd3
    } arm_state_t;

    // Channel index: 0 = arm, 1 = sensor, 2 = on.
    logic [2:0]    s1_r;
    logic [2:0]    s2_r;
    logic [2:0]    db_r;
    logic [CW-1:0] cnt_r [3];
    logic          sensor_db_d_r;
    logic          rise_s;
    logic          glitch_s;
    arm_state_t    state_r;
    logic [HW-1:0] hcnt_r;

    assign arm_db    = db_r[0];
    assign sensor_db = db_r[1];
    assign on_out    = db_r[2];

    assign rise_s   = db_r[1] & ~sensor_db_d_r;
    assign glitch_s = (s2_r[1] == db_r[1]) && (cnt_r[1] != CNT_ZERO);

    // Two-flop synchronizers for the raw pad inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 3'b000;
            s2_r <= 3'b000;
        end else begin
            s1_r <= {raw_on, raw_sensor, raw_arm};
            s2_r <= s1_r;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            db_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2_r[i] == db_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_MAX) begin
                    db_r[i]  <= s2_r[i];
                    cnt_r[i] <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Sensor rise pulse, sticky trip (a new rise beats clear) and glitch counter (clear wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sensor_db_d_r <= 1'b0;
            sensor_edge   <= 1'b0;
            sensor_out    <= 1'b0;
            glitch_cnt    <= 4'd0;
        end else begin
            sensor_db_d_r <= db_r[1];
            sensor_edge   <= rise_s;
            if (rise_s) begin
                sensor_out <= 1'b1;
            end else if (clear) begin
                sensor_out <= 1'b0;
            end else begin
                sensor_out <= sensor_out;
            end
            if (clear) begin
                glitch_cnt <= 4'd0;
            end else if (glitch_s && (glitch_cnt != 4'd15)) begin
                glitch_cnt <= glitch_cnt + 4'd1;
            end else begin
                glitch_cnt <= glitch_cnt;
            end
        end
    end

    // Long-press arm FSM: one pulse per press, no repeat while the button stays down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            hcnt_r  <= HOLD_ZERO;
            arm_out <= 1'b0;
        end else begin
            arm_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (db_r[0]) begin
                        state_r <= HOLD;
                        hcnt_r  <= HOLD_ONE;
                    end else begin
                        hcnt_r  <= HOLD_ZERO;
                    end
                end
                HOLD: begin
                    if (!db_r[0]) begin
                        state_r <= IDLE;
                        hcnt_r  <= HOLD_ZERO;
                    end else if (hcnt_r == HOLD_MAX) begin
                        state_r <= FIRE;
                        arm_out <= 1'b1;
                    end else begin
                        hcnt_r  <= hcnt_r + HOLD_ONE;
                    end
                end
                FIRE: begin
                    hcnt_r  <= HOLD_ZERO;
                    state_r <= db_r[0] ? WAIT_REL : IDLE;
                end
                WAIT_REL: begin
                    if (!db_r[0]) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_REL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    hcnt_r  <= HOLD_ZERO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_input_conditioner.sv
// Bench for alarm_input_conditioner: directed table, corner sequences and random stimulus
// checked every cycle against a run-length reference model.
module tb_alarm_input_conditioner;
    localparam int D = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       raw_arm = 1'b0;
    logic       raw_sensor = 1'b0;
    logic       raw_on = 1'b0;
    logic       clear = 1'b0;
    logic       arm_out, sensor_out, on_out, sensor_edge, arm_db, sensor_db;
    logic [3:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    alarm_input_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .raw_arm(raw_arm), .raw_sensor(raw_sensor),
        .raw_on(raw_on), .clear(clear), .arm_out(arm_out), .sensor_out(sensor_out),
        .on_out(on_out), .sensor_edge(sensor_edge), .arm_db(arm_db),
        .sensor_db(sensor_db), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: raw delayed two edges, level flips after D disagreeing samples,
    // arm pulse when the debounced arm level has been high for exactly H edges.
    bit hist0 [3];
    bit hist1 [3];
    int run   [3];
    bit lvl   [3];
    bit prev_sdb;
    int arm_run;
    bit m_arm_out, m_sensor_out, m_sensor_edge;
    int m_glitch;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            hist0[c] = 0; hist1[c] = 0; run[c] = 0; lvl[c] = 0;
        end
        prev_sdb = 0; arm_run = 0; m_arm_out = 0; m_sensor_out = 0;
        m_sensor_edge = 0; m_glitch = 0;
    endtask

    task automatic model_step();
        bit raw_v [3];
        bit edge_n, gl, synced;
        raw_v[0] = raw_arm; raw_v[1] = raw_sensor; raw_v[2] = raw_on;
        edge_n = lvl[1] && !prev_sdb;
        prev_sdb = lvl[1];
        arm_run = lvl[0] ? arm_run + 1 : 0;
        m_arm_out = (arm_run == H);
        gl = 0;
        for (int c = 0; c < 3; c++) begin
            synced = hist1[c];
            if (synced == lvl[c]) begin
                if (c == 1 && run[c] != 0) gl = 1;
                run[c] = 0;
            end else begin
                run[c]++;
                if (run[c] == D) begin
                    lvl[c] = synced;
                    run[c] = 0;
                end
            end
            hist1[c] = hist0[c];
            hist0[c] = raw_v[c];
        end
        if (edge_n) m_sensor_out = 1;
        else if (clear) m_sensor_out = 0;
        if (clear) m_glitch = 0;
        else if (gl && m_glitch < 15) m_glitch++;
        m_sensor_edge = edge_n;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("arm_out", int'(arm_out), int'(m_arm_out));
        chk("sensor_out", int'(sensor_out), int'(m_sensor_out));
        chk("on_out", int'(on_out), int'(lvl[2]));
        chk("sensor_edge", int'(sensor_edge), int'(m_sensor_edge));
        chk("arm_db", int'(arm_db), int'(lvl[0]));
        chk("sensor_db", int'(sensor_db), int'(lvl[1]));
        chk("glitch_cnt", int'(glitch_cnt), m_glitch);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_arm_out"}, int'(arm_out), 0);
        chk({tag, "_sensor_out"}, int'(sensor_out), 0);
        chk({tag, "_on_out"}, int'(on_out), 0);
        chk({tag, "_sensor_edge"}, int'(sensor_edge), 0);
        chk({tag, "_arm_db"}, int'(arm_db), 0);
        chk({tag, "_sensor_db"}, int'(sensor_db), 0);
        chk({tag, "_glitch_cnt"}, int'(glitch_cnt), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic glitch_pulses(input int n);
        for (int g = 0; g < n; g++) begin
            raw_sensor = 1'b1; ticks(2);
            raw_sensor = 1'b0; ticks(3);
        end
    endtask

    typedef struct {
        bit rs;
        bit cl;
        bit e_db;
        bit e_edge;
        bit e_out;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int pulses, pulse_at, db_at;
        bit saw_db;
        int hold_left [3];
        bit val [3];

        vecs[0] = '{1, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 0};
        vecs[2] = '{1, 0, 0, 0, 0};
        vecs[3] = '{1, 0, 0, 0, 0};
        vecs[4] = '{1, 0, 0, 0, 0};
        vecs[5] = '{1, 0, 1, 0, 0};
        vecs[6] = '{1, 0, 1, 1, 1};
        vecs[7] = '{1, 0, 1, 0, 1};
        vecs[8] = '{1, 1, 1, 0, 0};
        vecs[9] = '{1, 0, 1, 0, 0};

        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        ticks(10);

        // Sensor rise, sticky trip, clear.
        for (int i = 0; i < 10; i++) begin
            raw_sensor = vecs[i].rs;
            clear = vecs[i].cl;
            tick();
            chk($sformatf("vec%0d_sensor_db", i), int'(sensor_db), int'(vecs[i].e_db));
            chk($sformatf("vec%0d_sensor_edge", i), int'(sensor_edge), int'(vecs[i].e_edge));
            chk($sformatf("vec%0d_sensor_out", i), int'(sensor_out), int'(vecs[i].e_out));
        end
        clear = 1'b0;

        // Glitches never reach sensor_db; counter saturates at 15.
        raw_sensor = 1'b0; ticks(8);
        clear = 1'b1; tick(); clear = 1'b0;
        saw_db = 0;
        for (int g = 0; g < 3; g++) begin
            raw_sensor = 1'b1; tick(); saw_db |= sensor_db; tick(); saw_db |= sensor_db;
            raw_sensor = 1'b0;
            for (int k = 0; k < 3; k++) begin tick(); saw_db |= sensor_db; end
        end
        ticks(3);
        chk("glitch_db_never_high", int'(saw_db), 0);
        chk("glitch_sensor_out", int'(sensor_out), 0);
        chk("glitch_cnt_3", int'(glitch_cnt), 3);
        glitch_pulses(17);
        ticks(3);
        chk("glitch_cnt_sat", int'(glitch_cnt), 15);

        // Long arm press: single pulse at edge 13.
        pulses = 0; pulse_at = -1; db_at = -1;
        raw_arm = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (arm_db && db_at < 0) db_at = i;
            if (arm_out) begin pulses++; if (pulse_at < 0) pulse_at = i; end
        end
        chk("arm_db_rise_edge", db_at, 5);
        chk("arm_pulse_edge", pulse_at, 13);
        chk("arm_pulse_count", pulses, 1);
        raw_arm = 1'b0; ticks(12);
        chk("arm_released_db", int'(arm_db), 0);

        // Short press (arm_db high 5 cycles) gives nothing; a full press gives one pulse.
        pulses = 0;
        raw_arm = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); pulses += int'(arm_out); end
        raw_arm = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(); pulses += int'(arm_out); end
        chk("arm_short_press", pulses, 0);
        raw_arm = 1'b1;
        for (int i = 0; i < 30; i++) begin tick(); pulses += int'(arm_out); end
        chk("arm_full_press", pulses, 1);
        raw_arm = 1'b0; ticks(12);

        // Rise coincident with clear keeps the trip; clear while level high stays cleared.
        raw_sensor = 1'b0; ticks(8);
        clear = 1'b1; tick(); clear = 1'b0;
        raw_sensor = 1'b1;
        ticks(6);
        clear = 1'b1; tick();
        chk("set_wins_edge", int'(sensor_edge), 1);
        chk("set_wins_out", int'(sensor_out), 1);
        tick();
        chk("clear_high_out", int'(sensor_out), 0);
        tick();
        clear = 1'b0;
        chk("clear_again_out", int'(sensor_out), 0);
        ticks(3);
        chk("no_reset_without_rise", int'(sensor_out), 0);

        // Reset mid-HOLD with a trip and glitches pending, inputs held high across release.
        raw_sensor = 1'b0; ticks(8);
        clear = 1'b1; tick(); clear = 1'b0;
        glitch_pulses(5);
        ticks(2);
        chk("pre_reset_glitch", int'(glitch_cnt), 5);
        raw_sensor = 1'b1; raw_arm = 1'b1; raw_on = 1'b1;
        ticks(9);
        chk("pre_reset_sensor_out", int'(sensor_out), 1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("held_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) begin
                chk("relatency_arm_db_e4", int'(arm_db), 0);
                chk("relatency_sensor_db_e4", int'(sensor_db), 0);
                chk("relatency_on_e4", int'(on_out), 0);
            end
            if (i == 5) begin
                chk("relatency_arm_db_e5", int'(arm_db), 1);
                chk("relatency_sensor_db_e5", int'(sensor_db), 1);
                chk("relatency_on_e5", int'(on_out), 1);
            end
        end

        // Random stimulus with random hold lengths so both glitches and stable levels occur.
        for (int c = 0; c < 3; c++) begin hold_left[c] = 0; val[c] = 0; end
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold_left[c] == 0) begin
                    val[c] = bit'($urandom_range(0, 1));
                    hold_left[c] = $urandom_range(1, 12);
                end
                hold_left[c]--;
            end
            raw_arm = val[0]; raw_sensor = val[1]; raw_on = val[2];
            clear = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
